// File: rtl/mem_sequencer_pkg.sv
// Shared types and constants for the memory sequencer: FSM state encoding,
// core memory-op encoding and the NOP loaded into the instruction holder.
package riscV_unrn_pkg;

    typedef enum logic [2:0] {
        FETCH_REQ  = 3'd0,
        FETCH_WAIT = 3'd1,
        EXEC       = 3'd2,
        DATA_REQ   = 3'd3,
        DATA_WAIT  = 3'd4,
        COMMIT     = 3'd5
    } mem_seq_state_t;

    typedef enum logic [1:0] {
        MEM_SIZE_B    = 2'b00,
        MEM_SIZE_H    = 2'b01,
        MEM_SIZE_W    = 2'b10,
        MEM_SIZE_NONE = 2'b11
    } mem_size_t;

    // bit2 = store, bits[1:0] = access size
    typedef struct packed {
        logic      store;
        mem_size_t size;
    } mem_inst_type_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/mem_sequencer_if.sv
// Single-port memory bus between the sequencer (master) and the memory (slave).
interface mem_sequencer_if;

    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    modport master (
        output mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );

    modport slave (
        input  mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );

endinterface

// File: rtl/mem_lane_gen.sv
// Byte-lane steering for data accesses: byte enables from size and the low
// address bits, store data replicated across the lanes it may land on.
module mem_lane_gen
    import riscV_unrn_pkg::*;
(
    input  mem_size_t   size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o
);

    // Lane selection per access size; no-access yields no enables.
    always_comb begin
        be_o    = 4'b0000;
        wdata_o = 32'h0;
        case (size_i)
            MEM_SIZE_B: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            MEM_SIZE_H: begin
                be_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
                wdata_o = {2{wdata_i[15:0]}};
            end
            MEM_SIZE_W: begin
                be_o    = 4'hF;
                wdata_o = wdata_i;
            end
            default: begin
                be_o    = 4'b0000;
                wdata_o = 32'h0;
            end
        endcase
    end

endmodule

// File: rtl/mem_sequencer.sv
// Multi-cycle fetch/data sequencer sharing one single-port memory bus.
// Optional bus watchdog enabled by defining MEM_SEQ_TIMEOUT_EN.
//
// state      | meaning
// FETCH_REQ  | fetch request on the bus at the PC word address
// FETCH_WAIT | waiting for the instruction response
// EXEC       | core decodes held instruction; step here if no data phase
// DATA_REQ   | load/store request on the bus
// DATA_WAIT  | waiting for the data response (stores wait too)
// COMMIT     | step pulse after a data phase
module mem_sequencer
    import riscV_unrn_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [31:0]    pc_i,
    input  mem_inst_type_t inst_type_i,
    input  logic [31:0]    data_addr_i,
    input  logic [31:0]    wdata_i,
    input  logic           exc_i,
    output logic [31:0]    instr_o,
    output logic [31:0]    rdata_o,
    output logic           step_o,
    mem_sequencer_if.master bus
`ifdef MEM_SEQ_TIMEOUT_EN
    ,
    output logic           bus_err_o
`endif
);

    mem_seq_state_t state_q, state_d;
    logic [31:0]    instr_q, instr_d;
    logic [31:0]    rdata_q, rdata_d;

    logic           req_c;
    logic [31:0]    addr_c;
    logic           we_c;
    logic [3:0]     be_c;
    logic [31:0]    wdata_c;
    logic [3:0]     lane_be;
    logic [31:0]    lane_wdata;

`ifdef MEM_SEQ_TIMEOUT_EN
    localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                    $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             tmo;

    assign cnt_inc = cnt_q + CNT_W'(1);
    // Fires on the cycle the wait count reaches the limit, measured from grant.
    assign tmo     = (cnt_inc == CNT_W'(TIMEOUT_CYCLES));

    logic unused_bits;
    assign unused_bits = ^pc_i[1:0];
`else
    logic unused_bits;
    assign unused_bits = (^pc_i[1:0]) ^ (TIMEOUT_CYCLES == 0);
`endif

    mem_lane_gen u_lane (
        .size_i   (inst_type_i.size),
        .addr_lo_i(data_addr_i[1:0]),
        .wdata_i  (wdata_i),
        .be_o     (lane_be),
        .wdata_o  (lane_wdata)
    );

    // State, instruction holder and load-data holder registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FETCH_REQ;
            instr_q <= NOP_INSTR;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef MEM_SEQ_TIMEOUT_EN
    // Watchdog count of cycles spent in a WAIT state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    // Next-state, capture and bus-request decode.
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        rdata_d = rdata_q;
        step_o  = 1'b0;
        req_c   = 1'b0;
        addr_c  = 32'h0;
        we_c    = 1'b0;
        be_c    = 4'b0000;
        wdata_c = 32'h0;
`ifdef MEM_SEQ_TIMEOUT_EN
        bus_err_o = 1'b0;
        cnt_d     = '0;
`endif
        case (state_q)
            FETCH_REQ: begin
                req_c  = 1'b1;
                addr_c = {pc_i[31:2], 2'b00};
                be_c   = 4'hF;
                if (bus.mem_gnt_i) state_d = FETCH_WAIT;
            end
            FETCH_WAIT: begin
                if (bus.mem_rvalid_i) begin
                    instr_d = bus.mem_rdata_i;
                    state_d = EXEC;
                end
`ifdef MEM_SEQ_TIMEOUT_EN
                else begin
                    cnt_d = cnt_inc;
                    if (tmo) begin
                        // Zero decodes as illegal so the core traps.
                        bus_err_o = 1'b1;
                        instr_d   = 32'h0;
                        state_d   = EXEC;
                    end
                end
`endif
            end
            EXEC: begin
                if (inst_type_i.size == MEM_SIZE_NONE || exc_i) begin
                    step_o  = 1'b1;
                    state_d = FETCH_REQ;
                end else begin
                    state_d = DATA_REQ;
                end
            end
            DATA_REQ: begin
                req_c   = 1'b1;
                addr_c  = {data_addr_i[31:2], 2'b00};
                we_c    = inst_type_i.store;
                be_c    = lane_be;
                wdata_c = lane_wdata;
                if (bus.mem_gnt_i) state_d = DATA_WAIT;
            end
            DATA_WAIT: begin
                if (bus.mem_rvalid_i) begin
                    rdata_d = bus.mem_rdata_i;
                    state_d = COMMIT;
                end
`ifdef MEM_SEQ_TIMEOUT_EN
                else begin
                    cnt_d = cnt_inc;
                    if (tmo) begin
                        bus_err_o = 1'b1;
                        rdata_d   = 32'h0;
                        state_d   = COMMIT;
                    end
                end
`endif
            end
            COMMIT: begin
                step_o  = 1'b1;
                state_d = FETCH_REQ;
            end
            default: begin
                state_d = FETCH_REQ;
            end
        endcase
    end

    // The reset state is FETCH_REQ, so the request is masked while held in reset.
    assign bus.mem_req_o   = req_c & rst;
    assign bus.mem_addr_o  = addr_c;
    assign bus.mem_we_o    = we_c;
    assign bus.mem_be_o    = be_c;
    assign bus.mem_wdata_o = wdata_c;

    assign instr_o = instr_q;
    assign rdata_o = rdata_q;

endmodule

// File: doc/mem_sequencer.md
# mem_sequencer

Multi-cycle sequencer that lets the single-cycle core share one single-port memory bus for instruction fetch and data access. It sits between the core and the memory. Each instruction is fetched into a holding register, and a data phase is issued when the instruction is a load or store. A one-cycle `step_o` pulse tells the core when to commit its PC, register-file and CSR updates.

## Interface
- `TIMEOUT_CYCLES`, default 255: bus watchdog limit in cycles from grant to response. Only used with `MEM_SEQ_TIMEOUT_EN`.
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-low reset.
- `pc_i` in 32: core PC, used as the fetch address.
- `inst_type_i` in `mem_inst_type_t`: core memory op. bit2=1 means store; [1:0] 00 byte, 01 half, 10 word, 11 no access.
- `data_addr_i` in 32: core data address (ALU result).
- `wdata_i` in 32: store data (rs2).
- `exc_i` in 1: core exception present. Suppresses the data phase.
- `instr_o` out 32: held instruction to core decode.
- `rdata_o` out 32: held load data to core.
- `step_o` out 1: commit pulse to core.
- `mem_req_o` out 1, `mem_addr_o` out 32, `mem_we_o` out 1, `mem_be_o` out 4, `mem_wdata_o` out 32: bus request.
- `mem_gnt_i` in 1: request accepted.
- `mem_rvalid_i` in 1, `mem_rdata_i` in 32: response.
- `bus_err_o` out 1: timeout pulse. Present only with the macro.

## Operation
- FSM states: FETCH_REQ, FETCH_WAIT, EXEC, DATA_REQ, DATA_WAIT, COMMIT.
- FETCH_REQ:
  - Drives `mem_req_o`=1, `mem_addr_o`=`{pc_i[31:2],2'b00}`, `mem_we_o`=0, `mem_be_o`=4'hF.
  - On `mem_gnt_i`, goes to FETCH_WAIT.
- FETCH_WAIT:
  - On `mem_rvalid_i`, captures `instr_o`<=`mem_rdata_i` and goes to EXEC.
- EXEC: the core settles combinationally on `instr_o`.
  - If `inst_type_i[1:0]`==11 or `exc_i`=1: pulse `step_o` and go to FETCH_REQ.
  - Otherwise go to DATA_REQ.
- DATA_REQ:
  - Drives `mem_req_o`=1, `mem_addr_o`=`{data_addr_i[31:2],2'b00}`, `mem_we_o`=`inst_type_i[2]`.
  - Byte enables: byte gives `4'b0001<<a[1:0]`; half gives `4'b0011<<{a[1],1'b0}`; word gives 4'hF. Here a = `data_addr_i`.
  - Write data: byte replicated ×4, half replicated ×2, word as is.
  - On `mem_gnt_i`, goes to DATA_WAIT.
- DATA_WAIT:
  - On `mem_rvalid_i`, captures `rdata_o`<=`mem_rdata_i` (stores also wait for their response) and goes to COMMIT.
- COMMIT: pulses `step_o` and goes to FETCH_REQ.
- Request outputs are stable while `mem_req_o`=1 and `mem_gnt_i`=0. Core inputs are held constant, because the core does not change state without `step_o`.
- `mem_req_o`=0 in the WAIT, EXEC and COMMIT states.
- At most one transaction is outstanding.
- `mem_rvalid_i` is ignored outside FETCH_WAIT and DATA_WAIT.
- Misalignment is not checked here; it is reported by the core through `exc_i`.

## Timing
- Reset values:
  - State: FETCH_REQ.
  - `instr_o`=32'h0000_0013 (NOP).
  - `rdata_o`=0, `step_o`=0, `bus_err_o`=0, `mem_req_o`=0 while `rst`=0.
- Reset assertion mid-transaction abandons it. The first cycle after deassertion issues a fetch.
- Grant may arrive in the same cycle as the request. Response arrives one or more cycles after grant, never in the grant cycle.
- Zero-wait bus: `step_o` every 3 cycles for a non-memory instruction, every 6 cycles for a load or store.
- `exc_i` is sampled only in EXEC. A store with `exc_i`=1 never reaches the bus.

## Configuration
- `MEM_SEQ_TIMEOUT_EN` defined:
  - An 8+ bit counter clears on entry to each WAIT state and increments while waiting.
  - When it reaches `TIMEOUT_CYCLES`, `bus_err_o` pulses for 1 cycle.
  - In a fetch timeout, `instr_o`<=0 (illegal instruction, so the core traps) and the FSM goes to EXEC.
  - In a data timeout, `rdata_o`<=0 and the FSM goes to COMMIT.
- `MEM_SEQ_TIMEOUT_EN` undefined:
  - No counter and no `bus_err_o` port; the WAIT states wait forever.

## Structure
- `riscV_unrn_pkg` holds:
  - `mem_seq_state_t` enum.
  - `NOP_INSTR` constant 32'h0000_0013.
  - Size encodings `MEM_SIZE_B`/`MEM_SIZE_H`/`MEM_SIZE_W`/`MEM_SIZE_NONE`.
- Sub-module `mem_lane_gen` (combinational) produces `mem_be_o` and `mem_wdata_o` from size, `a[1:0]` and `wdata_i`. The FSM, capture registers and watchdog live in the top.

## Test plan
- Zero-wait bus, pc_i=0x8000_0004 with an ADDI: fetch address 0x8000_0004, `instr_o` updated after rvalid, `step_o` in cycle 3, no data request.
- SW with addr 0x100 and wdata 0xDEADBEEF: data request has we=1, be=4'hF, wdata 0xDEADBEEF; `step_o` in cycle 6.
- SB at addr 0x103, wdata 0x000000A5: be=4'b1000, wdata=0xA5A5A5A5, `mem_addr_o`=0x100.
- LH at 0x102 with 3-cycle grant delay and rvalid data 0x12345678: request held stable 3 cycles; be=4'b1100; `rdata_o`=0x12345678 at COMMIT.
- Load with `exc_i`=1 in EXEC: no data request; `step_o` pulses in EXEC. Also: `rst` low during DATA_WAIT leads to FETCH_REQ, `instr_o`=NOP, and a late rvalid is ignored.
- With the macro and `TIMEOUT_CYCLES`=4, withhold rvalid on a fetch: `bus_err_o` pulses 4 cycles after grant, `instr_o`=0, then `step_o`.
